mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a data (load/store) port and an instruction-fetch port
// share one memory bus, with data priority, bounded fetch starvation and a busy timeout.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in flight; arbitrate pending requests
// D_BUSY | data access on the memory bus, waiting for i_m_ack
// F_BUSY | fetch access on the memory bus, waiting for i_m_ack
// RESP   | one-cycle ack to the winner; no grant, avoids re-serving a held req
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_be,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_d_stall,
    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        o_f_ack,
    output logic [31:0] o_f_inst,
    output logic        o_f_stall,
    output logic        o_m_req,
    output logic        o_m_we,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    output logic [3:0]  o_m_be,
    input  logic        i_m_ack,
    input  logic [31:0] i_m_rdata,
    output logic        o_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BUSY_LAST  = BW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        F_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] busy_cnt;
    logic          grant_d;
    logic          grant_f;
    logic          complete;
    logic          timeout;
    logic          busy;

    assign busy      = (state == D_BUSY) || (state == F_BUSY);
    assign o_m_req   = busy;
    assign o_d_stall = i_d_req & ~o_d_ack;
    assign o_f_stall = i_f_req & ~o_f_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_f    = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                // Data wins a tie until the fetch has waited STARVE_MAX data grants.
                if (i_d_req && (!i_f_req || (starve_cnt != STARVE_TOP))) begin
                    grant_d    = 1'b1;
                    next_state = D_BUSY;
                end else if (i_f_req) begin
                    grant_f    = 1'b1;
                    next_state = F_BUSY;
                end
            end
            D_BUSY, F_BUSY: begin
                if (i_m_ack) begin
                    complete   = 1'b1;
                    next_state = RESP;
                end else if (busy_cnt == BUSY_LAST) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_d_ack    <= 1'b0;
            o_f_ack    <= 1'b0;
            o_err      <= 1'b0;
            o_d_rdata  <= '0;
            o_f_inst   <= '0;
            o_m_we     <= 1'b0;
            o_m_addr   <= '0;
            o_m_wdata  <= '0;
            o_m_be     <= '0;
            starve_cnt <= '0;
            busy_cnt   <= '0;
        end else begin
            o_d_ack <= (state == D_BUSY) && (complete || timeout);
            o_f_ack <= (state == F_BUSY) && (complete || timeout);
            o_err   <= timeout;

            if (grant_d) begin
                o_m_we    <= i_d_we;
                o_m_addr  <= i_d_addr;
                o_m_wdata <= i_d_wdata;
                o_m_be    <= i_d_be;
                busy_cnt  <= '0;
                if (i_f_req && (starve_cnt != STARVE_TOP)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_f) begin
                o_m_we     <= 1'b0;
                o_m_addr   <= i_f_addr;
                o_m_wdata  <= '0;
                o_m_be     <= 4'hF;
                busy_cnt   <= '0;
                starve_cnt <= '0;
            end else if (busy && !i_m_ack) begin
                busy_cnt <= busy_cnt + 1'b1;
            end

            // An aborted access returns zero so the requester never sees stale data.
            if ((state == D_BUSY) && (complete || timeout)) begin
                o_d_rdata <= complete ? i_m_rdata : 32'h0;
            end
            if ((state == F_BUSY) && (complete || timeout)) begin
                o_f_inst <= complete ? i_m_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable memory model plus a scoreboard of
// expected accesses, compared whenever either requester is acknowledged.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic        i_clk;
    logic        i_rst;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_be;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;
    logic        o_d_stall;
    logic        i_f_req;
    logic [31:0] i_f_addr;
    logic        o_f_ack;
    logic [31:0] o_f_inst;
    logic        o_f_stall;
    logic        o_m_req;
    logic        o_m_we;
    logic [31:0] o_m_addr;
    logic [31:0] o_m_wdata;
    logic [3:0]  o_m_be;
    logic        i_m_ack;
    logic [31:0] i_m_rdata;
    logic        o_err;

    mem_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_d_req  (i_d_req),
        .i_d_we   (i_d_we),
        .i_d_addr (i_d_addr),
        .i_d_wdata(i_d_wdata),
        .i_d_be   (i_d_be),
        .o_d_ack  (o_d_ack),
        .o_d_rdata(o_d_rdata),
        .o_d_stall(o_d_stall),
        .i_f_req  (i_f_req),
        .i_f_addr (i_f_addr),
        .o_f_ack  (o_f_ack),
        .o_f_inst (o_f_inst),
        .o_f_stall(o_f_stall),
        .o_m_req  (o_m_req),
        .o_m_we   (o_m_we),
        .o_m_addr (o_m_addr),
        .o_m_wdata(o_m_wdata),
        .o_m_be   (o_m_be),
        .i_m_ack  (i_m_ack),
        .i_m_rdata(i_m_rdata),
        .o_err    (o_err)
    );

    typedef struct {
        logic        is_f;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // memory model controls: mem_lat = busy cycle carrying i_m_ack, 0 = never
    int          mem_lat     = 1;
    logic        use_fixed   = 1'b0;
    logic [31:0] mem_data    = 32'h0;
    logic        spurious    = 1'b0;
    int          busy_cycles = 0;
    int          last_len    = 0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        fields_moved;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic void push_exp(input logic is_f, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be,
                                     input logic [31:0] rdata, input logic err, input int len);
        exp_t e;
        e.is_f  = is_f;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.be    = be;
        e.rdata = rdata;
        e.err   = err;
        e.len   = len;
        sb.push_back(e);
    endfunction

    // memory model followed by the scoreboard monitor, in one process so the
    // busy length is always settled before an ack is scored
    initial begin
        exp_t e;
        i_m_ack   = 1'b0;
        i_m_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            if (o_m_req) begin
                if (busy_cycles == 0) begin
                    cap_we       = o_m_we;
                    cap_addr     = o_m_addr;
                    cap_wdata    = o_m_wdata;
                    cap_be       = o_m_be;
                    fields_moved = 1'b0;
                end else if (cap_we !== o_m_we || cap_addr !== o_m_addr ||
                             cap_wdata !== o_m_wdata || cap_be !== o_m_be) begin
                    fields_moved = 1'b1;
                end
                busy_cycles++;
                i_m_ack = (mem_lat != 0) && (busy_cycles == mem_lat);
            end else begin
                if (busy_cycles != 0) last_len = busy_cycles;
                busy_cycles = 0;
                i_m_ack     = spurious;
            end
            i_m_rdata = use_fixed ? mem_data : (o_m_addr ^ 32'hA5A5A5A5);

            if (o_err && !o_d_ack && !o_f_ack) check("err_without_ack", 32'(o_err), 32'd0);
            if (o_d_ack && o_f_ack) check("dual_ack", 32'(o_f_ack), 32'd0);
            if (o_d_ack || o_f_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port",  32'(o_f_ack), 32'(e.is_f));
                    check("m_we",      32'(cap_we), 32'(e.we));
                    check("m_addr",    cap_addr, e.addr);
                    check("m_wdata",   cap_wdata, e.wdata);
                    check("m_be",      32'(cap_be), 32'(e.be));
                    check("m_stable",  32'(fields_moved), 32'd0);
                    check("busy_len",  32'(last_len), 32'(e.len));
                    check("rdata",     o_f_ack ? o_f_inst : o_d_rdata, e.rdata);
                    check("err",       32'(o_err), 32'(e.err));
                end
            end
        end
    end

    task automatic run_single(input logic is_f, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input int lat,
                              input logic fixed, input logic [31:0] data,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_len);
        logic got;
        mem_lat   = lat;
        use_fixed = fixed;
        mem_data  = data;
        push_exp(is_f, is_f ? 1'b0 : we, addr, is_f ? 32'h0 : wdata, is_f ? 4'hF : be,
                 exp_rdata, exp_err, exp_len);
        @(negedge i_clk);
        if (is_f) begin
            i_f_req  = 1'b1;
            i_f_addr = addr;
        end else begin
            i_d_req   = 1'b1;
            i_d_we    = we;
            i_d_addr  = addr;
            i_d_wdata = wdata;
            i_d_be    = be;
        end
        @(negedge i_clk);
        check("m_req_after_grant", 32'(o_m_req), 32'd1);
        check("stall_waiting", 32'(is_f ? o_f_stall : o_d_stall), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge i_clk);
            if (is_f ? o_f_ack : o_d_ack) got = 1'b1;
        end
        if (got) check("stall_at_ack", 32'(is_f ? o_f_stall : o_d_stall), 32'd0);
        else     check("ack_wait", 32'd0, 32'd1);
        i_d_req = 1'b0;
        i_f_req = 1'b0;
    endtask

    initial begin
        int acks;
        int di;
        int fi;
        logic got;
        i_rst     = 1'b1;
        i_d_req   = 1'b0;
        i_d_we    = 1'b0;
        i_d_addr  = 32'h0;
        i_d_wdata = 32'h0;
        i_d_be    = 4'h0;
        i_f_req   = 1'b0;
        i_f_addr  = 32'h0;

        repeat (2) @(negedge i_clk);
        check("rst_m_req",  32'(o_m_req), 32'd0);
        check("rst_d_ack",  32'(o_d_ack), 32'd0);
        check("rst_f_ack",  32'(o_f_ack), 32'd0);
        check("rst_err",    32'(o_err), 32'd0);
        check("rst_m_addr", o_m_addr, 32'h0);
        check("rst_m_wdata", o_m_wdata, 32'h0);
        check("rst_m_be",   32'(o_m_be), 32'h0);
        check("rst_d_rdata", o_d_rdata, 32'h0);
        check("rst_f_inst", o_f_inst, 32'h0);
        i_rst = 1'b0;

        // single write, memory acks in its third busy cycle
        run_single(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3, 1'b1, 32'h0BADF00D,
                   32'h0BADF00D, 1'b0, 3);
        // fetch
        run_single(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 2, 1'b1, 32'h00500093,
                   32'h00500093, 1'b0, 2);

        // both requesting continuously, immediate memory ack
        di = 0;
        fi = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                push_exp(1'b1, 1'b0, 32'h2000 + 32'(4 * fi), 32'h0, 4'hF,
                         (32'h2000 + 32'(4 * fi)) ^ 32'hA5A5A5A5, 1'b0, 1);
                fi++;
            end else begin
                push_exp(1'b0, 1'b0, 32'h1000 + 32'(4 * di), 32'h0, 4'hF,
                         (32'h1000 + 32'(4 * di)) ^ 32'hA5A5A5A5, 1'b0, 1);
                di++;
            end
        end
        mem_lat   = 1;
        use_fixed = 1'b0;
        @(negedge i_clk);
        i_d_req   = 1'b1;
        i_d_we    = 1'b0;
        i_d_addr  = 32'h1000;
        i_d_wdata = 32'h0;
        i_d_be    = 4'hF;
        i_f_req   = 1'b1;
        i_f_addr  = 32'h2000;
        acks = 0;
        for (int i = 0; i < 100 && acks < 10; i++) begin
            @(negedge i_clk);
            if (o_d_ack) begin
                acks++;
                i_d_addr = i_d_addr + 32'd4;
            end
            if (o_f_ack) begin
                acks++;
                i_f_addr = i_f_addr + 32'd4;
            end
        end
        i_d_req = 1'b0;
        i_f_req = 1'b0;
        check("arb_ack_count", 32'(acks), 32'd10);

        // partial byte-enable read with address-derived data
        run_single(1'b0, 1'b0, 32'h204, 32'h0, 4'h3, 2, 1'b0, 32'h0,
                   32'h204 ^ 32'hA5A5A5A5, 1'b0, 2);
        // memory never answers: abort after TIMEOUT busy cycles
        run_single(1'b0, 1'b1, 32'h300, 32'h12345678, 4'hC, 0, 1'b1, 32'h77777777,
                   32'h0, 1'b1, TIMEOUT);
        // ack arrives on the last allowed busy cycle: completion beats timeout
        run_single(1'b0, 1'b0, 32'h304, 32'h0, 4'hF, TIMEOUT, 1'b1, 32'hCAFE0001,
                   32'hCAFE0001, 1'b0, TIMEOUT);

        // spurious ack while idle
        use_fixed = 1'b1;
        mem_data  = 32'hFFFFFFFF;
        spurious  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("spur_m_req",   32'(o_m_req), 32'd0);
            check("spur_d_ack",   32'(o_d_ack), 32'd0);
            check("spur_f_ack",   32'(o_f_ack), 32'd0);
            check("spur_d_rdata", o_d_rdata, 32'hCAFE0001);
        end
        spurious = 1'b0;
        @(negedge i_clk);

        // reset in the middle of a silent fetch, then the held fetch is re-arbitrated
        mem_lat  = 0;
        mem_data = 32'h11112222;
        @(negedge i_clk);
        i_f_req  = 1'b1;
        i_f_addr = 32'h80;
        repeat (3) @(negedge i_clk);
        check("busy_before_rst", 32'(o_m_req), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check("rst_mid_m_req",  32'(o_m_req), 32'd0);
        check("rst_mid_f_ack",  32'(o_f_ack), 32'd0);
        check("rst_mid_m_addr", o_m_addr, 32'h0);
        check("rst_mid_f_inst", o_f_inst, 32'h0);
        check("rst_mid_d_rdata", o_d_rdata, 32'h0);
        mem_lat = 2;
        push_exp(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 32'h11112222, 1'b0, 2);
        @(negedge i_clk);
        i_rst = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge i_clk);
            if (o_f_ack) got = 1'b1;
        end
        check("refetch_ack", 32'(got), 32'd1);
        i_f_req = 1'b0;

        repeat (3) @(negedge i_clk);
        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
